// File: rtl/sensor_input_conditioner.sv
// Purpose : synchronise, debounce and qualify the six raw irrigation field sensors.
// Latency : 2 sync edges + DEBOUNCE_COUNT sample ticks (PRESCALE=1: new level out at edge N+1+DEBOUNCE_COUNT).
// Backpress: none; level-based outputs that are always valid, no handshake.
//
// Ports:
//   clock, reset_n            : sole clock; synchronous active-low reset
//   *_raw                     : six asynchronous raw sensor levels
//   low/mid/high_water_level  : debounced water probes (registered)
//   earth/air_humidity,
//   low_temperature           : debounced climate sensors (registered)
//   sensors_ready             : debounced set is trustworthy (initial settle done)
//   sensor_fault              : sticky water-probe inconsistency flag
//
// Optional feature macro: SENSOR_FAULT_LATCH_EN
//   defined   -> water-probe inconsistency fault FSM is built
//   undefined -> sensor_fault is tied low
module sensor_input_conditioner #(
  parameter int PRESCALE       = 1000,
  parameter int DEBOUNCE_COUNT = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic low_water_level_raw,
  input  logic mid_water_level_raw,
  input  logic high_water_level_raw,
  input  logic earth_humidity_raw,
  input  logic air_humidity_raw,
  input  logic low_temperature_raw,
  output logic low_water_level,
  output logic mid_water_level,
  output logic high_water_level,
  output logic earth_humidity,
  output logic air_humidity,
  output logic low_temperature,
  output logic sensors_ready,
  output logic sensor_fault
);

  localparam int NCH = 6;
  localparam int PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CW  = $clog2(DEBOUNCE_COUNT + 1);

  localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] DB_LAST       = CW'(DEBOUNCE_COUNT - 1);

  // Channel order used throughout: bit 0 = low water ... bit 5 = low temperature.
  logic [NCH-1:0] raw_vec;
  logic [NCH-1:0] sync1;
  logic [NCH-1:0] sync2;
  logic [NCH-1:0] deb_out;

  assign raw_vec = {low_temperature_raw, air_humidity_raw, earth_humidity_raw,
                    high_water_level_raw, mid_water_level_raw, low_water_level_raw};

  // ------------------------------------------------------------------
  // Two-flop synchronisers
  // ------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_vec;
      sync2 <= sync1;
    end
  end

  // ------------------------------------------------------------------
  // Free-running sample prescaler
  // ------------------------------------------------------------------
  logic [PW-1:0] presc_cnt;
  logic          tick;

  // With PRESCALE=1 the counter is pinned at 0, so tick is high every cycle.
  assign tick = (presc_cnt == PRESCALE_LAST);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + PW'(1);
    end
  end

  // ------------------------------------------------------------------
  // Per-channel debounce: a new level must be seen on DEBOUNCE_COUNT
  // consecutive ticks; any tick agreeing with the output restarts the count.
  // ------------------------------------------------------------------
  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    logic [CW-1:0] cnt;
    logic          out_q;

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        cnt   <= '0;
        out_q <= 1'b0;
      end else if (tick) begin
        if (sync2[ch] == out_q) begin
          cnt <= '0;
        end else if (cnt == DB_LAST) begin
          out_q <= sync2[ch];
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end

    assign deb_out[ch] = out_q;
  end

  assign low_water_level  = deb_out[0];
  assign mid_water_level  = deb_out[1];
  assign high_water_level = deb_out[2];
  assign earth_humidity   = deb_out[3];
  assign air_humidity     = deb_out[4];
  assign low_temperature  = deb_out[5];

  // ------------------------------------------------------------------
  // Ready FSM: INIT counts DEBOUNCE_COUNT ticks after reset release.
  // run_q masks the tick that coincides with the release edge itself
  // (only possible when PRESCALE=1), so the settle period is always
  // DEBOUNCE_COUNT full ticks measured from the first out-of-reset edge.
  // ------------------------------------------------------------------
  typedef enum logic {RDY_INIT, RDY_READY} rdy_state_t;

  rdy_state_t    rdy_state;
  logic [CW-1:0] rdy_cnt;
  logic          run_q;
  logic          ready_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rdy_state <= RDY_INIT;
      rdy_cnt   <= '0;
      run_q     <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      run_q <= 1'b1;
      case (rdy_state)
        RDY_INIT: begin
          if (tick && run_q) begin
            if (rdy_cnt == DB_LAST) begin
              rdy_state <= RDY_READY;
              ready_q   <= 1'b1;
            end else begin
              rdy_cnt <= rdy_cnt + CW'(1);
            end
          end
        end
        RDY_READY: begin
          ready_q <= 1'b1;
        end
        default: begin
          rdy_state <= RDY_INIT;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign sensors_ready = ready_q;

  // ------------------------------------------------------------------
  // Optional water-probe consistency fault
  // ------------------------------------------------------------------
`ifdef SENSOR_FAULT_LATCH_EN
  typedef enum logic [1:0] {FLT_OK, FLT_SUSPECT, FLT_LATCHED} flt_state_t;

  flt_state_t flt_state;
  logic       fault_q;
  logic       invalid;

  // A higher probe wet while a lower one is dry cannot happen physically.
  assign invalid = (deb_out[2] & ~deb_out[1]) | (deb_out[1] & ~deb_out[0]);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      flt_state <= FLT_OK;
      fault_q   <= 1'b0;
    end else if (tick && ready_q) begin
      case (flt_state)
        FLT_OK: begin
          if (invalid) begin
            flt_state <= FLT_SUSPECT;
          end
        end
        FLT_SUSPECT: begin
          if (invalid) begin
            flt_state <= FLT_LATCHED;
            fault_q   <= 1'b1;
          end else begin
            flt_state <= FLT_OK;
          end
        end
        FLT_LATCHED: begin
          fault_q <= 1'b1;
        end
        default: begin
          flt_state <= FLT_OK;
          fault_q   <= 1'b0;
        end
      endcase
    end
  end

  assign sensor_fault = fault_q;
`else
  assign sensor_fault = 1'b0;
`endif

endmodule

// File: tb/tb_sensor_input_conditioner.sv
// Purpose : self-checking bench for sensor_input_conditioner (PRESCALE=1 and PRESCALE=10 instances).
// Latency : expectations are edge-exact for PRESCALE=1, windowed for PRESCALE=10.
// Backpress: n/a.
module tb_sensor_input_conditioner;

  logic       clock;
  logic       reset_n;
  logic [5:0] raw0;
  logic [5:0] raw1;
  wire  [5:0] o0;
  wire  [5:0] o1;
  wire        rdy0;
  wire        rdy1;
  wire        flt0;
  wire        flt1;

  int vectors;
  int miscompares;

`ifdef SENSOR_FAULT_LATCH_EN
  localparam logic FAULT_EXP = 1'b1;
`else
  localparam logic FAULT_EXP = 1'b0;
`endif

  sensor_input_conditioner #(.PRESCALE(1), .DEBOUNCE_COUNT(4)) u0 (
    .clock(clock), .reset_n(reset_n),
    .low_water_level_raw(raw0[0]), .mid_water_level_raw(raw0[1]),
    .high_water_level_raw(raw0[2]), .earth_humidity_raw(raw0[3]),
    .air_humidity_raw(raw0[4]), .low_temperature_raw(raw0[5]),
    .low_water_level(o0[0]), .mid_water_level(o0[1]), .high_water_level(o0[2]),
    .earth_humidity(o0[3]), .air_humidity(o0[4]), .low_temperature(o0[5]),
    .sensors_ready(rdy0), .sensor_fault(flt0)
  );

  sensor_input_conditioner #(.PRESCALE(10), .DEBOUNCE_COUNT(4)) u1 (
    .clock(clock), .reset_n(reset_n),
    .low_water_level_raw(raw1[0]), .mid_water_level_raw(raw1[1]),
    .high_water_level_raw(raw1[2]), .earth_humidity_raw(raw1[3]),
    .air_humidity_raw(raw1[4]), .low_temperature_raw(raw1[5]),
    .low_water_level(o1[0]), .mid_water_level(o1[1]), .high_water_level(o1[2]),
    .earth_humidity(o1[3]), .air_humidity(o1[4]), .low_temperature(o1[5]),
    .sensors_ready(rdy1), .sensor_fault(flt1)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    string      name;
    logic [5:0] raw;
    int         hold;
    logic [5:0] exp_out;
    logic       exp_rdy;
  } vec_t;

  typedef struct {
    string      name;
    logic [5:0] out;
    logic       rdy;
  } exp_t;

  vec_t tbl[16];
  exp_t sb[$];

  // Wait n rising edges, then land on the following falling edge for sampling/driving.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int   lat;
    exp_t e;

    vectors     = 0;
    miscompares = 0;

    // Channel bits: 0 low_water, 1 mid, 2 high, 3 earth, 4 air, 5 low_temp.
    tbl[0]  = '{"fall_n4",        6'b000000, 5, 6'b111111, 1'b1};
    tbl[1]  = '{"fall_n5",        6'b000000, 1, 6'b000000, 1'b1};
    tbl[2]  = '{"mid_step_n4",    6'b000010, 5, 6'b000000, 1'b1};
    tbl[3]  = '{"mid_step_n5",    6'b000010, 1, 6'b000010, 1'b1};
    tbl[4]  = '{"multi_n4",       6'b101101, 5, 6'b000010, 1'b1};
    tbl[5]  = '{"multi_n5",       6'b101101, 1, 6'b101101, 1'b1};
    tbl[6]  = '{"air_glitch3",    6'b111101, 3, 6'b101101, 1'b1};
    tbl[7]  = '{"air_glitch_rej", 6'b101101, 8, 6'b101101, 1'b1};
    tbl[8]  = '{"air_pulse4",     6'b111101, 4, 6'b101101, 1'b1};
    tbl[9]  = '{"air_pulse4_rise",6'b101101, 2, 6'b111101, 1'b1};
    tbl[10] = '{"air_pulse4_hold",6'b101101, 3, 6'b111101, 1'b1};
    tbl[11] = '{"air_pulse4_fall",6'b101101, 1, 6'b101101, 1'b1};
    tbl[12] = '{"all_invert",     6'b010010, 6, 6'b010010, 1'b1};
    tbl[13] = '{"bounce_hi2",     6'b010011, 2, 6'b010010, 1'b1};
    tbl[14] = '{"bounce_lo1",     6'b010010, 1, 6'b010010, 1'b1};
    tbl[15] = '{"bounce_hi5",     6'b010011, 5, 6'b010010, 1'b1};

    // ---------------- reset with all raw inputs high ----------------
    raw0    = 6'h3f;
    raw1    = 6'h00;
    reset_n = 1'b0;
    @(negedge clock);
    step(3);
    check("rst_out",   {2'b0, o0}, 8'h00);
    check("rst_ready", {7'b0, rdy0}, 8'h00);
    check("rst_fault", {7'b0, flt0}, 8'h00);

    reset_n = 1'b1;                     // next rising edge is R
    step(4);                            // R..R+3
    check("rel_r3_ready", {7'b0, rdy0}, 8'h00);
    check("rel_r3_out",   {2'b0, o0}, 8'h00);
    step(1);                            // R+4
    check("rel_r4_ready", {7'b0, rdy0}, 8'h01);
    check("rel_r4_out",   {2'b0, o0}, 8'h00);
    step(1);                            // R+5
    check("rel_r5_out",   {2'b0, o0}, 8'h3f);
    step(33);                           // R+38: prescaled instance has seen 3 ticks
    check("pre_ready_r38", {7'b0, rdy1}, 8'h00);
    step(1);                            // R+39: 4th tick of the PRESCALE=10 instance
    check("pre_ready_r39", {7'b0, rdy1}, 8'h01);

    // ---------------- table-driven vectors (PRESCALE=1) ----------------
    for (int i = 0; i < 16; i++) begin
      raw0 = tbl[i].raw;
      sb.push_back('{tbl[i].name, tbl[i].exp_out, tbl[i].exp_rdy});
      step(tbl[i].hold);
      e = sb.pop_front();
      check(e.name, {1'b0, rdy0, o0}, {1'b0, e.rdy, e.out});
    end
    // bounced low_water finally accepted on the 4th consecutive tick
    step(1);
    check("bounce_accept", {2'b0, o0}, 8'h13);

    // ---------------- prescaled step ----------------
    raw1 = 6'b001000;
    lat  = -1;
    for (int k = 1; k <= 60; k++) begin
      step(1);
      if (lat < 0 && o1[3] === 1'b1) lat = k - 1;
    end
    vectors++;
    if (!(lat >= 32 && lat <= 42)) begin
      miscompares++;
      $display("FAIL prescale_latency: got %0d cycles, required 32..42", lat);
    end
    check("pre_final_out", {2'b0, o1}, 8'h08);

    // ---------------- mid-operation reset ----------------
    raw0 = 6'b000000;
    step(6);
    check("mor_clear", {2'b0, o0}, 8'h00);
    raw0 = 6'b100000;
    step(5);                            // N..N+4: low_temperature cnt now 3
    check("mor_pre", {2'b0, o0}, 8'h00);
    reset_n = 1'b0;
    step(1);                            // would have been the accepting edge
    check("mor_out",   {2'b0, o0}, 8'h00);
    check("mor_ready", {7'b0, rdy0}, 8'h00);
    reset_n = 1'b1;
    step(4);                            // R..R+3
    check("mor_r3", {1'b0, rdy0, o0}, 8'h00);
    step(1);                            // R+4
    check("mor_r4", {1'b0, rdy0, o0}, 8'h40);
    step(1);                            // R+5
    check("mor_r5", {1'b0, rdy0, o0}, 8'h60);

    // ---------------- water-probe fault ----------------
    raw0 = 6'b100001;
    step(6);
    check("flt_base", {2'b0, o0}, 8'h21);
    raw0 = 6'b100101;                   // high probe first (edge N)
    step(1);
    raw0 = 6'b100111;                   // mid probe one edge later
    step(5);                            // N+5: high accepted, mid not yet
    check("flt_1tick_out", {2'b0, o0}, 8'h25);
    step(1);                            // N+6: consistent again
    check("flt_1tick_fix", {2'b0, o0}, 8'h27);
    step(3);
    check("flt_1tick_nofault", {7'b0, flt0}, 8'h00);

    raw0 = 6'b100101;                   // mid drops: high & ~mid
    step(6);                            // M+5
    check("flt_inv_out", {2'b0, o0}, 8'h25);
    step(1);                            // M+6: first invalid tick
    check("flt_suspect", {7'b0, flt0}, 8'h00);
    step(1);                            // M+7: second invalid tick
    check("flt_latch", {7'b0, flt0}, {7'b0, FAULT_EXP});
    raw0 = 6'b100111;
    step(10);
    check("flt_sticky",     {7'b0, flt0}, {7'b0, FAULT_EXP});
    check("flt_data_clean", {2'b0, o0}, 8'h27);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
